// File: rtl/id_pkg.sv
// Shared decode-stage definitions: immediate format codes and instruction field positions.
package id_pkg;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4,
    IMM_R = 3'd5
  } imm_sel_e;

  localparam int unsigned RdLsb  = 7;
  localparam int unsigned Rs1Lsb = 15;
  localparam int unsigned Rs2Lsb = 20;

endpackage

// File: rtl/id_regfile.sv
// Register file: two asynchronous read ports with write-through bypass, one synchronous write
// port, x0 hardwired to zero.
module id_regfile #(
  parameter  int unsigned XLEN  = 32,
  parameter  int unsigned NREGS = 32,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [AW-1:0]   raddr1_i,
  input  logic [AW-1:0]   raddr2_i,
  output logic [XLEN-1:0] rdata1_o,
  output logic [XLEN-1:0] rdata2_o,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [XLEN-1:0] wdata_i
);

  logic [XLEN-1:0] mem_q [NREGS];
  logic [XLEN-1:0] mem_d [NREGS];
  logic            wr_en;

  assign wr_en = we_i && (waddr_i != '0) && (int'(waddr_i) < int'(NREGS));

  function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] addr);
    if (addr == '0 || int'(addr) >= int'(NREGS)) begin
      return '0;
    end else if (wr_en && waddr_i == addr) begin
      return wdata_i;
    end else begin
      return mem_q[addr];
    end
  endfunction

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[waddr_i] = wdata_i;
    end
  end

  always_comb begin
    rdata1_o = read_port(raddr1_i);
    rdata2_o = read_port(raddr2_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/id_stage_pipe.sv
// Decode stage: operand read, immediate generation, load-use hazard detection and the ID/EX
// pipeline register with flush > ex_stall > hazard > advance priority.
module id_stage_pipe
  import id_pkg::*;
#(
  parameter  int unsigned XLEN  = 32,
  parameter  int unsigned NREGS = 32,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [31:0]     id_inst,
  input  logic [XLEN-1:0] id_pc,
  input  logic [2:0]      imm_sel,
  input  logic            id_is_load,
  input  logic            wb_regwen,
  input  logic [AW-1:0]   wb_addrd,
  input  logic [XLEN-1:0] wb_datad,
  input  logic            ex_stall,
  input  logic            flush,
  output logic            id_stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_data_a,
  output logic [XLEN-1:0] ex_data_b,
  output logic [XLEN-1:0] ex_imm,
  output logic [AW-1:0]   ex_rs1,
  output logic [AW-1:0]   ex_rs2,
  output logic [AW-1:0]   ex_rd,
  output logic            ex_is_load
);

  logic [AW-1:0]   rs1, rs2, rd;
  logic [XLEN-1:0] rdata1, rdata2, imm;
  logic            use_rs1, use_rs2, hazard;
  logic            unused_inst;

  logic            ex_valid_q, ex_valid_d, ex_is_load_q, ex_is_load_d;
  logic [XLEN-1:0] ex_pc_q, ex_pc_d, ex_data_a_q, ex_data_a_d;
  logic [XLEN-1:0] ex_data_b_q, ex_data_b_d, ex_imm_q, ex_imm_d;
  logic [AW-1:0]   ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d, ex_rd_q, ex_rd_d;

  assign rs1 = id_inst[Rs1Lsb +: AW];
  assign rs2 = id_inst[Rs2Lsb +: AW];
  assign rd  = id_inst[RdLsb +: AW];
  assign unused_inst = ^{id_inst[6:0], id_inst[14:12]};

  id_regfile #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_regfile (
    .clk_i    (clk),
    .rst_ni   (rst),
    .raddr1_i (rs1),
    .raddr2_i (rs2),
    .rdata1_o (rdata1),
    .rdata2_o (rdata2),
    .we_i     (wb_regwen),
    .waddr_i  (wb_addrd),
    .wdata_i  (wb_datad)
  );

  always_comb begin
    imm     = '0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (imm_sel)
      IMM_I: begin
        imm     = {{(XLEN-12){id_inst[31]}}, id_inst[31:20]};
        use_rs1 = 1'b1;
      end
      IMM_S: begin
        imm     = {{(XLEN-12){id_inst[31]}}, id_inst[31:25], id_inst[11:7]};
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      IMM_B: begin
        imm     = {{(XLEN-12){id_inst[31]}}, id_inst[7], id_inst[30:25], id_inst[11:8], 1'b0};
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      IMM_U: imm = {{(XLEN-31){id_inst[31]}}, id_inst[30:12], 12'b0};
      IMM_J: imm = {{(XLEN-20){id_inst[31]}}, id_inst[19:12], id_inst[20], id_inst[30:21], 1'b0};
      // R-type has no immediate but reads both sources
      IMM_R: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      default: ;
    endcase
  end

  assign hazard = ex_valid_q && ex_is_load_q && (ex_rd_q != '0) && id_valid &&
                  ((use_rs1 && rs1 == ex_rd_q) || (use_rs2 && rs2 == ex_rd_q));

  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_pc_d      = ex_pc_q;
    ex_data_a_d  = ex_data_a_q;
    ex_data_b_d  = ex_data_b_q;
    ex_imm_d     = ex_imm_q;
    ex_rs1_d     = ex_rs1_q;
    ex_rs2_d     = ex_rs2_q;
    ex_rd_d      = ex_rd_q;
    ex_is_load_d = ex_is_load_q;
    id_stall     = 1'b0;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (ex_stall) begin
      id_stall = 1'b1;
    end else if (hazard) begin
      ex_valid_d = 1'b0;
      id_stall   = 1'b1;
    end else begin
      ex_valid_d   = id_valid;
      ex_pc_d      = id_pc;
      ex_data_a_d  = rdata1;
      ex_data_b_d  = rdata2;
      ex_imm_d     = imm;
      ex_rs1_d     = rs1;
      ex_rs2_d     = rs2;
      ex_rd_d      = rd;
      ex_is_load_d = id_is_load;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid_q   <= 1'b0;
      ex_pc_q      <= '0;
      ex_data_a_q  <= '0;
      ex_data_b_q  <= '0;
      ex_imm_q     <= '0;
      ex_rs1_q     <= '0;
      ex_rs2_q     <= '0;
      ex_rd_q      <= '0;
      ex_is_load_q <= 1'b0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_pc_q      <= ex_pc_d;
      ex_data_a_q  <= ex_data_a_d;
      ex_data_b_q  <= ex_data_b_d;
      ex_imm_q     <= ex_imm_d;
      ex_rs1_q     <= ex_rs1_d;
      ex_rs2_q     <= ex_rs2_d;
      ex_rd_q      <= ex_rd_d;
      ex_is_load_q <= ex_is_load_d;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_pc      = ex_pc_q;
  assign ex_data_a  = ex_data_a_q;
  assign ex_data_b  = ex_data_b_q;
  assign ex_imm     = ex_imm_q;
  assign ex_rs1     = ex_rs1_q;
  assign ex_rs2     = ex_rs2_q;
  assign ex_rd      = ex_rd_q;
  assign ex_is_load = ex_is_load_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: directed scenarios followed by random traffic, checked against a
// behavioural model of the decode stage.
module tb_id_stage_pipe;
  import id_pkg::*;

  logic        clk, rst;
  logic        id_valid, id_is_load, wb_regwen, ex_stall, flush;
  logic [31:0] id_inst, id_pc, wb_datad;
  logic [2:0]  imm_sel;
  logic [4:0]  wb_addrd;
  logic        id_stall, ex_valid, ex_is_load;
  logic [31:0] ex_pc, ex_data_a, ex_data_b, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;

  id_stage_pipe #(.XLEN(32), .NREGS(32)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc),
    .imm_sel(imm_sel), .id_is_load(id_is_load), .wb_regwen(wb_regwen), .wb_addrd(wb_addrd),
    .wb_datad(wb_datad), .ex_stall(ex_stall), .flush(flush), .id_stall(id_stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_data_a(ex_data_a), .ex_data_b(ex_data_b),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_is_load(ex_is_load)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_regs [32];
  logic        m_valid, m_is_load;
  logic [31:0] m_pc, m_a, m_b, m_imm;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  int          n_checks, n_pass, n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_imm(input logic [31:0] i, input logic [2:0] s);
    logic signed [31:0] si;
    si = i;
    case (s)
      3'd0: return 32'(si >>> 20);
      3'd1: return 32'((si >>> 25) <<< 5) | 32'(i[11:7]);
      3'd2: return (32'(si >>> 31) << 12) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) |
                   (32'(i[11:8]) << 1);
      3'd3: return i & 32'hFFFFF000;
      3'd4: return (32'(si >>> 31) << 20) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11) |
                   (32'(i[30:21]) << 1);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic reads1(input logic [2:0] s);
    return s == 3'd0 || s == 3'd1 || s == 3'd2 || s == 3'd5;
  endfunction

  function automatic logic reads2(input logic [2:0] s);
    return s == 3'd1 || s == 3'd2 || s == 3'd5;
  endfunction

  function automatic logic [31:0] rd_val(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wb_regwen && wb_addrd != 5'd0 && wb_addrd == a) return wb_datad;
    return m_regs[a];
  endfunction

  function automatic logic m_hazard();
    return m_valid && m_is_load && m_rd != 5'd0 && id_valid &&
           ((reads1(imm_sel) && id_inst[19:15] == m_rd) ||
            (reads2(imm_sel) && id_inst[24:20] == m_rd));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_valid = 0; m_is_load = 0; m_pc = 0; m_a = 0; m_b = 0; m_imm = 0;
    m_rs1 = 0; m_rs2 = 0; m_rd = 0;
  endtask

  task automatic model_edge();
    logic        hz;
    logic [31:0] a, b;
    hz = m_hazard();
    a  = rd_val(id_inst[19:15]);
    b  = rd_val(id_inst[24:20]);
    if (wb_regwen && wb_addrd != 5'd0) m_regs[wb_addrd] = wb_datad;
    if (flush || (!ex_stall && hz)) begin
      m_valid = 0;
    end else if (!ex_stall) begin
      m_valid = id_valid; m_pc = id_pc; m_a = a; m_b = b;
      m_imm = ref_imm(id_inst, imm_sel);
      m_rs1 = id_inst[19:15]; m_rs2 = id_inst[24:20]; m_rd = id_inst[11:7];
      m_is_load = id_is_load;
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic [2:0] sel, input logic ld, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd, input logic st,
                       input logic fl);
    id_valid = v; id_inst = inst; id_pc = pc; imm_sel = sel; id_is_load = ld;
    wb_regwen = we; wb_addrd = wa; wb_datad = wd; ex_stall = st; flush = fl;
  endtask

  // Called just after a negedge with inputs driven; advances one clock and checks.
  task automatic tick(input string tag);
    #1;
    chk({tag, "_id_stall"}, 32'(id_stall), 32'(!flush && (ex_stall || m_hazard())));
    @(posedge clk);
    model_edge();
    #1;
    chk({tag, "_ex_valid"}, 32'(ex_valid), 32'(m_valid));
    if (m_valid) begin
      chk({tag, "_ex_pc"}, ex_pc, m_pc);
      chk({tag, "_ex_a"}, ex_data_a, m_a);
      chk({tag, "_ex_b"}, ex_data_b, m_b);
      chk({tag, "_ex_imm"}, ex_imm, m_imm);
      chk({tag, "_ex_rs"}, {17'd0, ex_rs1, ex_rs2, ex_rd}, {17'd0, m_rs1, m_rs2, m_rd});
      chk({tag, "_ex_ld"}, 32'(ex_is_load), 32'(m_is_load));
    end
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(ex_valid), 32'd0);
    chk({tag, "_pc"}, ex_pc, 32'd0);
    chk({tag, "_ab_imm"}, ex_data_a | ex_data_b | ex_imm, 32'd0);
    chk({tag, "_idx_ld"}, {16'd0, ex_rs1, ex_rs2, ex_rd, ex_is_load}, 32'd0);
    chk({tag, "_id_stall"}, 32'(id_stall), 32'd0);
  endtask

  function automatic logic [31:0] mk(input logic [4:0] rd, input logic [4:0] r1,
                                     input logic [4:0] r2);
    return {7'd0, r2, r1, 3'd0, rd, 7'h33};
  endfunction

  initial begin
    logic [31:0] ri;
    n_checks = 0; n_pass = 0; n_fail = 0;
    rst = 0;
    drive(0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    #1 chk_zero("reset");
    rst = 1;
    @(negedge clk);

    // Write-through: WB writes x5 while ID reads rs1=5
    drive(1, mk(5'd3, 5'd5, 5'd0), 32'h100, 3'd0, 0, 1, 5'd5, 32'hDEADBEEF, 0, 0);
    tick("wt");
    chk("wt_a_const", ex_data_a, 32'hDEADBEEF);

    // x0 writes dropped
    drive(0, 0, 32'h104, 3'd0, 0, 1, 5'd0, 32'h1234, 0, 0);
    tick("x0w");
    drive(1, mk(5'd1, 5'd0, 5'd5), 32'h108, 3'd5, 0, 0, 0, 0, 0, 0);
    tick("x0r");
    chk("x0_a_const", ex_data_a, 32'd0);
    chk("x5_b_const", ex_data_b, 32'hDEADBEEF);

    // Load-use: lw x7 then add x8,x7,x1
    drive(1, {12'h004, 5'd2, 3'b010, 5'd7, 7'h03}, 32'h200, 3'd0, 1, 0, 0, 0, 0, 0);
    tick("lw");
    drive(1, mk(5'd8, 5'd7, 5'd1), 32'h204, 3'd5, 0, 0, 0, 0, 0, 0);
    #1 chk("hz_stall_const", 32'(id_stall), 32'd1);
    tick("hz_bubble");
    chk("hz_bubble_const", 32'(ex_valid), 32'd0);
    tick("hz_issue");
    chk("hz_issue_rd", {ex_valid, 26'd0, ex_rd}, {1'b1, 26'd0, 5'd8});
    // lui x7 after lw x7 does not read a source
    drive(1, {12'h004, 5'd2, 3'b010, 5'd7, 7'h03}, 32'h208, 3'd0, 1, 0, 0, 0, 0, 0);
    tick("lw2");
    drive(1, {12'h000, 5'd7, 3'd0, 5'd7, 7'h37}, 32'h20C, 3'd3, 0, 0, 0, 0, 0, 0);
    #1 chk("lui_nostall", 32'(id_stall), 32'd0);
    tick("lui");

    // Immediates
    drive(1, 32'hFE000EE3, 32'h300, 3'd2, 0, 0, 0, 0, 0, 0);
    tick("immb");
    chk("immb_const", ex_imm, 32'hFFFFFFFC);
    drive(1, 32'hFFF00093, 32'h304, 3'd0, 0, 0, 0, 0, 0, 0);
    tick("immi");
    chk("immi_const", ex_imm, 32'hFFFFFFFF);
    drive(1, 32'hFFFFFFFF, 32'h308, 3'd6, 0, 0, 0, 0, 0, 0);
    tick("immx");
    chk("immx_const", ex_imm, 32'd0);

    // Flush beats ex_stall and hazard
    drive(1, {12'h004, 5'd2, 3'b010, 5'd7, 7'h03}, 32'h400, 3'd0, 1, 0, 0, 0, 0, 0);
    tick("lw3");
    drive(1, mk(5'd8, 5'd7, 5'd1), 32'h404, 3'd5, 0, 0, 0, 0, 1, 1);
    #1 chk("flush_nostall", 32'(id_stall), 32'd0);
    tick("flush");
    chk("flush_invalid", 32'(ex_valid), 32'd0);
    // ex_stall alone freezes a live entry
    drive(1, mk(5'd9, 5'd5, 5'd5), 32'h500, 3'd5, 0, 0, 0, 0, 0, 0);
    tick("pre_hold");
    drive(1, mk(5'd10, 5'd1, 5'd2), 32'h504, 3'd0, 1, 1, 5'd5, 32'h55, 1, 0);
    tick("hold1");
    tick("hold2");
    chk("hold_pc", ex_pc, 32'h500);
    chk("hold_a", ex_data_a, 32'hDEADBEEF);

    // Asynchronous reset mid-operation with a live entry
    drive(1, {12'h004, 5'd2, 3'b010, 5'd7, 7'h03}, 32'h600, 3'd0, 1, 0, 0, 0, 0, 0);
    tick("pre_rst");
    rst = 0;
    #1 chk_zero("midrst");
    model_reset();
    rst = 1;
    drive(1, mk(5'd1, 5'd5, 5'd7), 32'h700, 3'd5, 0, 0, 0, 0, 0, 0);
    tick("post_rst");
    chk("post_rst_ab", ex_data_a | ex_data_b, 32'd0);

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      ri = $urandom;
      ri[11:7]  = 5'($urandom_range(0, 7));
      ri[19:15] = 5'($urandom_range(0, 7));
      ri[24:20] = 5'($urandom_range(0, 7));
      drive(1'($urandom_range(0, 3) != 0), ri, $urandom, 3'($urandom_range(0, 5)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            $urandom, 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 9) == 0));
      tick("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
